f2h_dma_req_arbiter: RTL
========================

# f2h_dma_req_arbiter

Shares the two HPS FPGA-to-HPS DMA peripheral-request channels (`f2h_dma_req0`, `f2h_dma_req1`) among up to `NUM_REQ` fabric requesters, e.g. the ALSA capture and playback engines and the SPI master. It runs the 4-phase PL330 req/ack handshake toward the HPS and a simple req/ack-pulse handshake toward each requester. It sits in `soc_system` between the peripheral DMA conduits and the `hps_0` DMA request ports. A per-channel watchdog flags HPS acks that never arrive.

## Interface
Parameters:
- `NUM_REQ`, 4 — number of requesters, 2..8.
- `TIMEOUT`, 1024 — cycles in REQ before abort; 0 disables the watchdog.

Ports:
- `clk_clk` in 1 — single clock domain.
- `reset_reset` in 1 — asynchronous, active-high reset.
- `enable` in NUM_REQ — per-requester arbitration enable (from CSR).
- `rq_req` in NUM_REQ — requester burst/single request, level.
- `rq_single` in NUM_REQ — 1 = single transfer, 0 = burst; sampled at grant.
- `rq_ack` out NUM_REQ — 1-cycle completion pulse to requester.
- `hps_dma_req` out 2 — to `f2h_dma_reqN_dma_req`.
- `hps_dma_single` out 2 — to `f2h_dma_reqN_dma_single`.
- `hps_dma_ack` in 2 — from `f2h_dma_reqN_dma_ack`.
- `ch_busy` out 2 — channel state != IDLE.
- `ch_owner` out 2*IDW — granted requester index per channel; IDW = clog2(NUM_REQ).
- `ch_err` out 2 — sticky timeout flag per channel.
- `err_clr` in 1 — clears `ch_err` (both channels).

## Operation
- Per-channel FSM, states IDLE, REQ, ACKHI.
- Eligible requester i: `rq_req[i] & enable[i]`, and i is not the owner of a non-IDLE channel.
- IDLE:
  - If any requester is eligible, latch `owner` from the round-robin pick and latch `single = rq_single[owner]`.
  - Next state REQ; `hps_dma_req` goes to 1 on the same edge.
- REQ:
  - Hold `hps_dma_req = 1` and `hps_dma_single = latched single`.
  - On sampled `hps_dma_ack = 1`: next state ACKHI, `hps_dma_req` goes to 0, `rq_ack[owner]` goes to 1 for exactly one cycle.
  - Watchdog counts cycles in REQ. At count == TIMEOUT-1 with no ack: next state IDLE, `hps_dma_req` goes to 0, set `ch_err`, no `rq_ack` (the requester is re-arbitrated later).
- ACKHI: wait for sampled `hps_dma_ack = 0`, then go to IDLE. The owner stays reserved while in this state.
- Round robin:
  - A single shared pointer selects the first eligible index at or above `ptr`, wrapping.
  - Both channels IDLE in the same cycle: ch0 takes the first pick; ch1 takes the next eligible index after ch0's pick, excluding it.
  - The pointer advances to (last index granted this cycle)+1 mod NUM_REQ; it is unchanged if nothing is granted.
- Requester rule: deassert `rq_req` no later than the edge on which `rq_ack = 1` is sampled.
- Clearing `enable[i]` never aborts an in-flight transfer; it only blocks new grants.
- `err_clr` and a timeout in the same cycle: set wins.
- Reset (asynchronous, any state): both FSMs IDLE, `ptr = 0`, counters 0. All outputs reset to 0: `rq_ack`, `hps_dma_req`, `hps_dma_single`, `ch_busy`, `ch_owner`, `ch_err`.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Grant latency: `rq_req` high in cycle t (channel IDLE) → `hps_dma_req = 1` in cycle t+1.
- HPS ack sampled in cycle t → `rq_ack` and `hps_dma_req = 0` in cycle t+1.
- ACKHI lasts at least 1 cycle, so the earliest IDLE is t+2. A registered requester has therefore dropped `rq_req` before the channel re-arbitrates.
- Back-to-back throughput per channel is 3 cycles per transfer when the HPS ack is a 1-cycle pulse.
- Timeout: `ch_err` rises TIMEOUT cycles after entry to REQ.

## Structure
- `soc_dma_arb_pkg`: state enum (IDLE, REQ, ACKHI), `IDW` width function, `NUM_CH = 2` constant.
- One sub-module, `rr_picker`: combinational rotate-priority encoder. Inputs are the request vector, the pointer and an exclude mask; outputs are `valid` and `idx`. It is instantiated twice (ch0, ch1 chained through the exclude mask).
- The FSMs live in a generate loop over `NUM_CH`.

## Test plan
- Single requester: `rq_req[2]` = 1, ch0 IDLE → `hps_dma_req[0]` = 1 next cycle, `ch_owner[0] = 2`. Ack pulse → `rq_ack[2]` = 1 for one cycle, `hps_dma_req[0]` = 0, ch0 IDLE 2 cycles after the ack.
- Simultaneous: requesters 0, 1, 3 all assert with `ptr = 0` → ch0 owner 0, ch1 owner 1, `ptr = 2`. After both complete, requester 3 is granted on ch0.
- Fairness: all 4 requesters held high with auto-ack → grant order 0,1,2,3,0… interleaved across channels, no requester starved over 100 transfers.
- Timeout, `TIMEOUT = 16`, no HPS ack → `hps_dma_req[0]` drops after 16 REQ cycles, `ch_err[0] = 1`, no `rq_ack`, request regranted. `err_clr` → `ch_err` = 0.
- `enable[1] = 0` with `rq_req[1]` = 1 → never granted. Deasserting `enable` for an owner mid-REQ still completes with `rq_ack`.
- Asserting `reset_reset` in REQ/ACKHI → all outputs 0 immediately (asynchronous). After release, normal grant from `ptr = 0`.

Source files
------------

// File: rtl/soc_dma_arb_pkg.sv
// soc_dma_arb_pkg: shared types and constants for the F2H DMA request arbiter
package soc_dma_arb_pkg;

    localparam int NUM_CH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACKHI = 2'd2
    } ch_state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idw(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: rotate-priority encoder, first masked request at or above ptr, wrapping
module rr_picker
    import soc_dma_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    input  logic [N-1:0] excl_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    logic [N-1:0] m;
    logic         hi_v;
    logic [W-1:0] hi, lo;

    assign m       = req_i & ~excl_i;
    assign valid_o = |m;
    assign idx_o   = hi_v ? hi : lo;

    // Lowest request at or above ptr, plus lowest overall for the wrap case.
    always_comb begin
        hi_v = 1'b0;
        hi   = '0;
        lo   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i] && i >= int'(ptr_i)) begin
                hi_v = 1'b1;
                hi   = W'(i);
            end
            if (m[i]) lo = W'(i);
        end
    end

endmodule

// File: rtl/f2h_dma_req_arbiter.sv
// f2h_dma_req_arbiter: shares the two HPS F2H DMA request channels among NUM_REQ requesters
module f2h_dma_req_arbiter
    import soc_dma_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int TIMEOUT = 1024,
    localparam int IDW     = idw(NUM_REQ)
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic [NUM_REQ-1:0]    enable,
    input  logic [NUM_REQ-1:0]    rq_req,
    input  logic [NUM_REQ-1:0]    rq_single,
    output logic [NUM_REQ-1:0]    rq_ack,
    output logic [NUM_CH-1:0]     hps_dma_req,
    output logic [NUM_CH-1:0]     hps_dma_single,
    input  logic [NUM_CH-1:0]     hps_dma_ack,
    output logic [NUM_CH-1:0]     ch_busy,
    output logic [NUM_CH*IDW-1:0] ch_owner,
    output logic [NUM_CH-1:0]     ch_err,
    input  logic                  err_clr
);

    localparam int            CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] TLAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

    logic [IDW-1:0]                ptr_q, ptr_d, ptr1, i0, i1;
    logic [NUM_REQ-1:0]            owned, elig, excl1, rq_ack_d;
    logic                          v0, v1, g0, g1;
    logic [NUM_CH-1:0]             ack_ev;
    logic [NUM_CH-1:0][IDW-1:0]    own;

    function automatic logic [IDW-1:0] inc(input logic [IDW-1:0] x);
        return (int'(x) == NUM_REQ - 1) ? '0 : x + IDW'(1);
    endfunction

    assign ch_owner = own;

    // Owners of non-IDLE channels stay reserved until their channel returns to IDLE.
    always_comb begin
        owned = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (ch_busy[c]) owned[own[c]] = 1'b1;
    end

    assign elig  = rq_req & enable & ~owned;
    assign g0    = v0 & ~ch_busy[0];
    assign g1    = v1 & ~ch_busy[1];
    assign ptr1  = g0 ? inc(i0) : ptr_q;
    assign excl1 = g0 ? (NUM_REQ'(1) << i0) : '0;
    assign ptr_d = g1 ? inc(i1) : g0 ? inc(i0) : ptr_q;

    rr_picker #(.N(NUM_REQ), .W(IDW)) u_pick0 (
        .req_i   (elig),
        .ptr_i   (ptr_q),
        .excl_i  ('0),
        .valid_o (v0),
        .idx_o   (i0)
    );

    // ch1 continues the rotation just past ch0's pick when both grant together.
    rr_picker #(.N(NUM_REQ), .W(IDW)) u_pick1 (
        .req_i   (elig),
        .ptr_i   (ptr1),
        .excl_i  (excl1),
        .valid_o (v1),
        .idx_o   (i1)
    );

    // Completion pulses routed to the owner of each acking channel.
    always_comb begin
        rq_ack_d = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (ack_ev[c]) rq_ack_d[own[c]] = 1'b1;
    end

    // Shared round-robin pointer and registered requester acks.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            ptr_q  <= '0;
            rq_ack <= '0;
        end else begin
            ptr_q  <= ptr_d;
            rq_ack <= rq_ack_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_state_t      st_q, st_d;
        logic [IDW-1:0] own_q, own_d, gi;
        logic [CW-1:0]  cnt_q, cnt_d;
        logic           sgl_q, sgl_d, err_q, err_d, gnt, ev;

        assign gi                = (c == 0) ? i0 : i1;
        assign gnt               = (c == 0) ? g0 : g1;
        assign own[c]            = own_q;
        assign ack_ev[c]         = ev;
        assign ch_busy[c]        = (st_q != IDLE);
        assign hps_dma_req[c]    = (st_q == REQ);
        assign hps_dma_single[c] = sgl_q;
        assign ch_err[c]         = err_q;

        // Channel state, latched grant and watchdog registers.
        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                st_q  <= IDLE;
                own_q <= '0;
                sgl_q <= 1'b0;
                cnt_q <= '0;
                err_q <= 1'b0;
            end else begin
                st_q  <= st_d;
                own_q <= own_d;
                sgl_q <= sgl_d;
                cnt_q <= cnt_d;
                err_q <= err_d;
            end
        end

        // Grant, HPS handshake and watchdog; an ack in the final watchdog cycle still completes.
        always_comb begin
            st_d  = st_q;
            own_d = own_q;
            sgl_d = sgl_q;
            cnt_d = cnt_q;
            err_d = err_clr ? 1'b0 : err_q;
            ev    = 1'b0;
            case (st_q)
                IDLE: if (gnt) begin
                    st_d  = REQ;
                    own_d = gi;
                    sgl_d = rq_single[gi];
                    cnt_d = '0;
                end
                REQ: if (hps_dma_ack[c]) begin
                    st_d = ACKHI;
                    ev   = 1'b1;
                end else if (TIMEOUT != 0 && cnt_q == TLAST) begin
                    st_d  = IDLE;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                ACKHI: if (!hps_dma_ack[c]) st_d = IDLE;
                default: st_d = IDLE;
            endcase
        end
    end

endmodule
